// File: rtl/instr_fetch_stage_pkg.sv
// instr_fetch_stage_pkg: opcodes, NOP word and fetch-state encoding shared by the fetch stage
package instr_fetch_stage_pkg;
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_SUBI  = 6'b001001;
  localparam logic [5:0] OPC_LWI   = 6'b001010;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000001;
  localparam logic [5:0] OPC_BLT   = 6'b000011;
  localparam logic [5:0] OPC_BGE   = 6'b000101;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_HALT  = 6'b111111;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/instr_fetch_stage_pc_reg.sv
// pc_reg: program counter with load, hold and wrapping increment
module pc_reg #(
  parameter int PC_W = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PC_W-1:0] load_pc,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);
  // load has priority over increment; increment wraps modulo 2^PC_W
  always_ff @(posedge clk or posedge rst)
    if (rst) pc <= RESET_PC;
    else if (load) pc <= load_pc;
    else if (inc) pc <= pc + 1'b1;
endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC, IF/ID register and BOOT/RUN/HALT fetch FSM; FETCH_PERF_CNT_EN adds fetch/bubble counters
module instr_fetch_stage import instr_fetch_stage_pkg::*; #(
  parameter int PC_W = 8,
  parameter int INSTR_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00,
  parameter logic [5:0] HALT_OPC = OPC_HALT
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc1,
  output logic               if_id_valid,
  output logic [5:0]         opcode,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        fetch_cnt,
  output logic [15:0]        bubble_cnt
`endif
);
  fetch_state_t state, state_n;
  logic [PC_W-1:0] pc;
  logic run, hit, pc_load, fetch, pc_inc, ifid_clr;
  pc_reg #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .load(pc_load), .load_pc(redirect_pc), .inc(pc_inc), .pc(pc)
  );
  assign imem_addr = pc;
  assign opcode = if_id_instr[INSTR_W-1 -: 6];
  assign halted = state == HALT;
  // redirect beats stall beats fetch; a captured HALT word freezes pc and enters HALT
  always_comb begin
    run = state == RUN;
    hit = imem_rdata[INSTR_W-1 -: 6] == HALT_OPC;
    pc_load = run && redirect;
    fetch = run && !redirect && !stall;
    pc_inc = fetch && !hit;
    ifid_clr = pc_load || state == HALT;
    state_n = state == BOOT ? RUN : (fetch && hit ? HALT : state);
  end
  // fetch state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= BOOT;
    else state <= state_n;
  // IF/ID pipeline register: flush to NOP, load on fetch, otherwise hold
  always_ff @(posedge clk or posedge rst)
    if (rst || ifid_clr) begin
      if_id_instr <= INSTR_W'(NOP_WORD);
      if_id_pc1 <= '0;
      if_id_valid <= 1'b0;
    end else if (fetch) begin
      if_id_instr <= imem_rdata;
      if_id_pc1 <= pc + 1'b1;
      if_id_valid <= 1'b1;
    end
`ifdef FETCH_PERF_CNT_EN
  logic bubble;
  assign bubble = run && (stall || redirect);
  // saturating fetch and bubble counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetch_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      if (fetch && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 1'b1;
      if (bubble && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 1'b1;
    end
`endif
endmodule
